nn_load_sequencer: RTL and testbench
====================================

# nn_load_sequencer

Controller that replaces hand-sequenced load/compute stimulus for `mnist_nn`. It accepts a serial 1-bit stream over a valid/ready handshake and writes it into the four weight banks and the input bank, generating select, address and write-strobe signals. It then hands the memories to the compute engine, waits for `compute_finish`, and returns the 4-bit class. It sits between the host/stream source and the `*_oc` load ports of `mnist_nn`.

## Interface
Parameters:
- `W_ADDR_LEN`, 20: weight address width.
- `X_ADDR_LEN`, 10: input address width.
- `W_SEL_LEN`, 2: weight bank select width.
- `X_SEL_LEN`, 2: input bank select width.
- `W1_WORDS`, 802816: words in bank 0 (784×1024).
- `W2_WORDS`, 1048576: words in bank 1.
- `W3_WORDS`, 1048576: words in bank 2.
- `W4_WORDS`, 10240: words in bank 3.
- `X_WORDS`, 784: input words per sample.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_weights` in 1: pulse; begin a full weight load.
- `start_sample` in 1: pulse; begin input load plus inference.
- `bit_valid` in 1: stream bit valid.
- `bit_data` in 1: stream bit.
- `bit_ready` out 1: block accepts a bit this cycle.
- `load_compute_ctrl` out 1: 1 = memories owned by the loader, 0 = owned by compute.
- `en_compute` out 1: compute enable.
- `w_wq_oc` out 1: weight write strobe.
- `x_wq_oc` out 1: input write strobe.
- `w_addr_oc` out W_ADDR_LEN: weight address.
- `x_addr_oc` out X_ADDR_LEN: input address.
- `w_sel_oc` out W_SEL_LEN: weight bank select.
- `x_sel_oc` out X_SEL_LEN: input bank select; always 0.
- `wx_write_oc` out 1: write data bit.
- `compute_finish` in 1: compute done, level.
- `result` in 4: class from compute.
- `result_out` out 4: captured class.
- `result_valid` out 1: one-cycle pulse when `result_out` updates.
- `weights_loaded` out 1: all four banks written since reset.
- `busy` out 1: state is not IDLE.
- `start_rejected` out 1: one-cycle pulse when a start request is ignored.

## Operation
- States: IDLE, LOAD_W, LOAD_X, HANDOFF, RUN, CAPTURE.
- IDLE:
  - `start_weights` → LOAD_W, with bank=0 and addr=0. It has priority if both starts assert together.
  - `start_sample` with `weights_loaded`=1 → LOAD_X, addr=0.
  - `start_sample` with `weights_loaded`=0 → stay in IDLE and pulse `start_rejected`.
- Any start while not in IDLE is ignored and pulses `start_rejected`.
- LOAD_W:
  - `bit_ready`=1; a beat is accepted when `bit_valid & bit_ready`.
  - Each accepted beat writes one bit to bank `w_sel_oc` at address `w_addr_oc`.
  - At address = WORDS(bank)−1: address clears and bank increments.
  - Last word of bank 3 → `weights_loaded`=1, return to IDLE.
- LOAD_X:
  - Same handshake; writes addresses 0..X_WORDS−1.
  - The last word moves the state to HANDOFF.
- HANDOFF: `load_compute_ctrl`=0 for one cycle, then RUN.
- RUN: `en_compute`=1 until `compute_finish`=1 is sampled, then CAPTURE.
- CAPTURE:
  - `result_out`←`result` and `result_valid`=1.
  - `en_compute`=0 and `load_compute_ctrl`=1.
  - Return to IDLE.
- `start_weights` while `weights_loaded`=1 reloads all banks. `weights_loaded` clears on entry to LOAD_W.
- `bit_ready`=0 in every state other than LOAD_W and LOAD_X. `bit_valid` in those states is ignored.
- Counter width is W_ADDR_LEN. Bank sizes up to 2^W_ADDR_LEN words are legal, and the last address 2^20−1 must not overflow before bank switch.

## Timing
- Reset values:
  - all strobes, `en_compute`, `result_valid`, `start_rejected`, `weights_loaded`, `busy`, `bit_ready` = 0;
  - `load_compute_ctrl`=1;
  - addresses, sels, `wx_write_oc`, `result_out` = 0;
  - state IDLE.
- Reset mid-load or mid-compute aborts immediately to these values. Partially written banks are considered invalid.
- All outputs are registered.
- A beat accepted at edge k drives `*_addr_oc`, `wx_write_oc` and one strobe high during cycle k→k+1. The memory captures the write at edge k+1.
- Strobes are high for exactly one cycle per accepted beat. Back-to-back beats give one write per cycle with no gaps.
- `bit_ready` rises the cycle after a start is accepted.
- After the last X beat's strobe cycle: `load_compute_ctrl` falls, and `en_compute` rises one cycle later.
- `compute_finish` is sampled at edge n. `result_valid` is high in cycle n+1→n+2, and `en_compute`/`load_compute_ctrl` restore in that same cycle.
- A `compute_finish` already high on the first RUN cycle is honoured.

## Structure
- Package `nn_ctrl_pkg`: state enum, bank-size constants, `bank_words(sel)` function.
- Sub-module `bank_addr_counter`:
  - address counter with terminal-count detect per bank;
  - bank increment and last-bank flag;
  - shared by LOAD_W and LOAD_X.

## Test plan
- Reduced sizes (W*_WORDS=4,4,4,2; X_WORDS=3), continuous `bit_valid`, 14 weight beats:
  - 4 strobes per bank 0,1,2 and 2 in bank 3;
  - addresses wrap 3→0 with sel incrementing;
  - `weights_loaded`=1 after beat 14.
- `bit_valid` toggling every other cycle during LOAD_X:
  - exactly 3 `x_wq_oc` pulses at addresses 0,1,2;
  - data matches the stream.
- After loading, `compute_finish` asserted 5 cycles into RUN with `result`=7:
  - `result_out`=7 and `result_valid` pulses once;
  - `load_compute_ctrl` returns to 1.
- `start_sample` issued before any weight load → `start_rejected` pulse and state stays IDLE.
- `start_weights` and `start_sample` in the same cycle → LOAD_W entered and no rejection pulse.
- `rst` asserted mid-LOAD_W (bank 1, address 2) → all outputs take their reset values, and `weights_loaded`=0.

Source files
------------

// File: rtl/nn_load_sequencer_pkg.sv
// Shared types and bank geometry for the MNIST load/compute sequencer.
// Bank sizes here are the full-network defaults; the top can override them.
package nn_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_X,
        S_HANDOFF,
        S_RUN,
        S_CAPTURE
    } state_t;

    localparam int unsigned W1_WORDS_DEF = 802816;
    localparam int unsigned W2_WORDS_DEF = 1048576;
    localparam int unsigned W3_WORDS_DEF = 1048576;
    localparam int unsigned W4_WORDS_DEF = 10240;
    localparam int unsigned X_WORDS_DEF  = 784;

    function automatic logic [31:0] bank_words(
        input logic [1:0]  sel,
        input logic [31:0] w1,
        input logic [31:0] w2,
        input logic [31:0] w3,
        input logic [31:0] w4
    );
        case (sel)
            2'd0:    return w1;
            2'd1:    return w2;
            2'd2:    return w3;
            default: return w4;
        endcase
    endfunction

endpackage

// File: rtl/nn_load_sequencer_if.sv
// Serial 1-bit load stream with a valid/ready handshake.
// The source drives valid/data; the sequencer drives ready.
interface nn_stream_if;

    logic bit_valid;
    logic bit_data;
    logic bit_ready;

    modport master (
        output bit_valid,
        output bit_data,
        input  bit_ready
    );

    modport slave (
        input  bit_valid,
        input  bit_data,
        output bit_ready
    );

endinterface

// File: rtl/nn_load_sequencer_bank_addr_counter.sv
// Write-address counter with per-bank terminal count and bank advance.
// The compare is done in 32 bits so a full 2^ADDR_LEN bank cannot wrap early.
module bank_addr_counter
    import nn_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_LEN = 20,
    parameter int unsigned W1       = W1_WORDS_DEF,
    parameter int unsigned W2       = W2_WORDS_DEF,
    parameter int unsigned W3       = W3_WORDS_DEF,
    parameter int unsigned W4       = W4_WORDS_DEF,
    parameter int unsigned XW       = X_WORDS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                step,
    input  logic                use_x,
    output logic [ADDR_LEN-1:0] addr,
    output logic [1:0]          bank,
    output logic                last_word,
    output logic                last_bank
);

    logic [31:0] words;

    always_comb begin
        words = use_x ? 32'(XW) : bank_words(bank, W1, W2, W3, W4);
        last_word = (32'(addr) == words - 32'd1);
        last_bank = (bank == 2'd3);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
            bank <= '0;
        end else if (clear) begin
            addr <= '0;
            bank <= '0;
        end else if (step) begin
            if (last_word) begin
                addr <= '0;
                // the input bank is a single region, so only weights advance
                if (!use_x)
                    bank <= bank + 2'd1;
            end else begin
                addr <= addr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/nn_load_sequencer.sv
// Streams weights and samples into mnist_nn memories, then runs one
// inference and captures the class; every output is registered.
module nn_load_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int unsigned W_ADDR_LEN = 20,
    parameter int unsigned X_ADDR_LEN = 10,
    parameter int unsigned W_SEL_LEN  = 2,
    parameter int unsigned X_SEL_LEN  = 2,
    parameter int unsigned W1_WORDS   = W1_WORDS_DEF,
    parameter int unsigned W2_WORDS   = W2_WORDS_DEF,
    parameter int unsigned W3_WORDS   = W3_WORDS_DEF,
    parameter int unsigned W4_WORDS   = W4_WORDS_DEF,
    parameter int unsigned X_WORDS    = X_WORDS_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_weights,
    input  logic                  start_sample,
    nn_stream_if.slave            stream,
    output logic                  load_compute_ctrl,
    output logic                  en_compute,
    output logic                  w_wq_oc,
    output logic                  x_wq_oc,
    output logic [W_ADDR_LEN-1:0] w_addr_oc,
    output logic [X_ADDR_LEN-1:0] x_addr_oc,
    output logic [W_SEL_LEN-1:0]  w_sel_oc,
    output logic [X_SEL_LEN-1:0]  x_sel_oc,
    output logic                  wx_write_oc,
    input  logic                  compute_finish,
    input  logic [3:0]            result,
    output logic [3:0]            result_out,
    output logic                  result_valid,
    output logic                  weights_loaded,
    output logic                  busy,
    output logic                  start_rejected
);

    state_t                state;
    logic                  ready_q;
    logic                  beat;
    logic                  go_w;
    logic                  go_x;
    logic [W_ADDR_LEN-1:0] cnt_addr;
    logic [1:0]            cnt_bank;
    logic                  last_word;
    logic                  last_bank;

    assign stream.bit_ready = ready_q;
    assign x_sel_oc         = '0;

    // ready_q is only ever high in the two load states
    assign beat = ready_q & stream.bit_valid;
    assign go_w = (state == S_IDLE) & start_weights;
    assign go_x = (state == S_IDLE) & ~start_weights
                & start_sample & weights_loaded;

    bank_addr_counter #(
        .ADDR_LEN (W_ADDR_LEN),
        .W1       (W1_WORDS),
        .W2       (W2_WORDS),
        .W3       (W3_WORDS),
        .W4       (W4_WORDS),
        .XW       (X_WORDS)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clear     (go_w | go_x),
        .step      (beat),
        .use_x     (state == S_LOAD_X),
        .addr      (cnt_addr),
        .bank      (cnt_bank),
        .last_word (last_word),
        .last_bank (last_bank)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= S_IDLE;
            ready_q           <= 1'b0;
            load_compute_ctrl <= 1'b1;
            en_compute        <= 1'b0;
            w_wq_oc           <= 1'b0;
            x_wq_oc           <= 1'b0;
            w_addr_oc         <= '0;
            x_addr_oc         <= '0;
            w_sel_oc          <= '0;
            wx_write_oc       <= 1'b0;
            result_out        <= '0;
            result_valid      <= 1'b0;
            weights_loaded    <= 1'b0;
            busy              <= 1'b0;
            start_rejected    <= 1'b0;
        end else begin
            w_wq_oc        <= 1'b0;
            x_wq_oc        <= 1'b0;
            result_valid   <= 1'b0;
            start_rejected <= 1'b0;

            if (state != S_IDLE && (start_weights || start_sample))
                start_rejected <= 1'b1;

            unique case (state)
                S_IDLE: begin
                    if (start_weights) begin
                        state          <= S_LOAD_W;
                        weights_loaded <= 1'b0;
                        ready_q        <= 1'b1;
                        busy           <= 1'b1;
                    end else if (start_sample) begin
                        if (weights_loaded) begin
                            state   <= S_LOAD_X;
                            ready_q <= 1'b1;
                            busy    <= 1'b1;
                        end else begin
                            start_rejected <= 1'b1;
                        end
                    end
                end
                S_LOAD_W: begin
                    if (beat) begin
                        w_wq_oc     <= 1'b1;
                        w_addr_oc   <= cnt_addr;
                        w_sel_oc    <= W_SEL_LEN'(cnt_bank);
                        wx_write_oc <= stream.bit_data;
                        if (last_word && last_bank) begin
                            weights_loaded <= 1'b1;
                            ready_q        <= 1'b0;
                            busy           <= 1'b0;
                            state          <= S_IDLE;
                        end
                    end
                end
                S_LOAD_X: begin
                    if (beat) begin
                        x_wq_oc     <= 1'b1;
                        x_addr_oc   <= X_ADDR_LEN'(cnt_addr);
                        wx_write_oc <= stream.bit_data;
                        if (last_word) begin
                            ready_q <= 1'b0;
                            state   <= S_HANDOFF;
                        end
                    end
                end
                S_HANDOFF: begin
                    load_compute_ctrl <= 1'b0;
                    state             <= S_RUN;
                end
                S_RUN: begin
                    en_compute <= 1'b1;
                    if (compute_finish)
                        state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    result_out        <= result;
                    result_valid      <= 1'b1;
                    en_compute        <= 1'b0;
                    load_compute_ctrl <= 1'b1;
                    busy              <= 1'b0;
                    state             <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nn_load_sequencer.sv
// Directed bench for nn_load_sequencer with reduced bank sizes
// (4,4,4,2 weight words, 3 input words).
module tb_nn_load_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_weights = 1'b0;
    logic        start_sample = 1'b0;
    logic        compute_finish = 1'b0;
    logic [3:0]  result = 4'd0;
    logic        load_compute_ctrl, en_compute, w_wq_oc, x_wq_oc;
    logic [19:0] w_addr_oc;
    logic [9:0]  x_addr_oc;
    logic [1:0]  w_sel_oc, x_sel_oc;
    logic        wx_write_oc;
    logic [3:0]  result_out;
    logic        result_valid, weights_loaded, busy, start_rejected;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rv_pulses = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [19:0] addr;
        logic        d;
        int          cyc;
    } wr_t;

    typedef struct {
        logic        d;
        logic [1:0]  sel;
        logic [19:0] addr;
    } wvec_t;

    wr_t   wlog[$];
    wr_t   xlog[$];
    wvec_t wexp[14];

    logic [13:0] wpat = 14'b01101001110110;
    logic [2:0]  xpat = 3'b101;

    always #5 clk = ~clk;

    nn_stream_if stream();

    nn_load_sequencer #(
        .W1_WORDS (4),
        .W2_WORDS (4),
        .W3_WORDS (4),
        .W4_WORDS (2),
        .X_WORDS  (3)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .start_weights     (start_weights),
        .start_sample      (start_sample),
        .stream            (stream),
        .load_compute_ctrl (load_compute_ctrl),
        .en_compute        (en_compute),
        .w_wq_oc           (w_wq_oc),
        .x_wq_oc           (x_wq_oc),
        .w_addr_oc         (w_addr_oc),
        .x_addr_oc         (x_addr_oc),
        .w_sel_oc          (w_sel_oc),
        .x_sel_oc          (x_sel_oc),
        .wx_write_oc       (wx_write_oc),
        .compute_finish    (compute_finish),
        .result            (result),
        .result_out        (result_out),
        .result_valid      (result_valid),
        .weights_loaded    (weights_loaded),
        .busy              (busy),
        .start_rejected    (start_rejected)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t e;
        if (w_wq_oc) begin
            e.sel = w_sel_oc; e.addr = w_addr_oc;
            e.d = wx_write_oc; e.cyc = cyc;
            wlog.push_back(e);
        end
        if (x_wq_oc) begin
            e.sel = x_sel_oc; e.addr = 20'(x_addr_oc);
            e.d = wx_write_oc; e.cyc = cyc;
            xlog.push_back(e);
        end
        if (result_valid) rv_pulses++;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse(input logic sw, input logic ss);
        @(posedge clk); #1;
        start_weights = sw;
        start_sample  = ss;
        @(posedge clk); #1;
        start_weights = 1'b0;
        start_sample  = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 14; i++) begin
            wexp[i].d = wpat[i];
            if (i < 12) begin
                wexp[i].sel  = 2'(i / 4);
                wexp[i].addr = 20'(i % 4);
            end else begin
                wexp[i].sel  = 2'd3;
                wexp[i].addr = 20'(i - 12);
            end
        end
        stream.bit_valid = 1'b0;
        stream.bit_data  = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ready", stream.bit_ready, 0);
        check("rst_lcc", load_compute_ctrl, 1);
        check("rst_wl", weights_loaded, 0);
        check("rst_en", en_compute, 0);
        check("rst_strobes", {w_wq_oc, x_wq_oc, result_valid}, 0);
        check("rst_result", result_out, 0);
        check("rst_xsel", x_sel_oc, 0);
        rst = 1'b0;

        // sample start with no weights
        pulse(1'b0, 1'b1);
        @(negedge clk);
        check("rej_pulse", start_rejected, 1);
        check("rej_idle", {busy, stream.bit_ready}, 0);
        @(negedge clk);
        check("rej_one_cycle", start_rejected, 0);

        // both starts together, then 14 back-to-back weight beats
        pulse(1'b1, 1'b1);
        @(negedge clk);
        check("both_busy", busy, 1);
        check("both_ready", stream.bit_ready, 1);
        check("both_no_rej", start_rejected, 0);
        for (int i = 0; i < 14; i++) begin
            stream.bit_data  = wexp[i].d;
            stream.bit_valid = 1'b1;
            if (i == 13) check("wl_before_last", weights_loaded, 0);
            @(posedge clk); #1;
        end
        stream.bit_valid = 1'b0;
        @(negedge clk);
        check("wl_after_last", weights_loaded, 1);
        check("w_idle", {busy, stream.bit_ready}, 0);
        @(negedge clk);
        check("w_count", wlog.size(), 14);
        for (int i = 0; i < wlog.size() && i < 14; i++)
            check($sformatf("w_write%0d", i),
                  {wlog[i].sel, wlog[i].addr, wlog[i].d},
                  {wexp[i].sel, wexp[i].addr, wexp[i].d});
        if (wlog.size() == 14)
            check("w_no_gaps", wlog[13].cyc - wlog[0].cyc, 13);

        // sample load with valid toggling every other cycle
        pulse(1'b0, 1'b1);
        for (int j = 0; j < 3; j++) begin
            stream.bit_valid = 1'b1;
            stream.bit_data  = xpat[j];
            @(posedge clk); #1;
            stream.bit_valid = 1'b0;
            stream.bit_data  = ~xpat[j];
            @(posedge clk); #1;
        end
        stream.bit_valid = 1'b1;
        @(negedge clk);
        check("handoff_lcc", load_compute_ctrl, 0);
        check("handoff_en", en_compute, 0);
        @(negedge clk);
        check("run_en", en_compute, 1);
        check("run_lcc_ready", {load_compute_ctrl, stream.bit_ready}, 0);
        pulse(1'b1, 1'b0);
        @(negedge clk);
        check("busy_rej", start_rejected, 1);
        check("busy_rej_run", {en_compute, busy}, 2'b11);
        @(posedge clk); #1;
        compute_finish = 1'b1;
        result = 4'd7;
        @(posedge clk); #1;
        compute_finish = 1'b0;
        @(negedge clk);
        check("cap_wait", {result_valid, en_compute}, 2'b01);
        @(posedge clk); #1;
        result = 4'd4;
        @(negedge clk);
        check("cap_valid", result_valid, 1);
        check("cap_result", result_out, 7);
        check("cap_restore", {en_compute, load_compute_ctrl}, 2'b01);
        @(posedge clk); #1;
        stream.bit_valid = 1'b0;
        @(negedge clk);
        check("cap_done", {result_valid, busy}, 0);
        check("cap_hold", result_out, 7);
        check("rv_pulses", rv_pulses, 1);
        check("x_count", xlog.size(), 3);
        for (int j = 0; j < xlog.size() && j < 3; j++)
            check($sformatf("x_write%0d", j),
                  {xlog[j].addr, xlog[j].d}, {20'(j), xpat[j]});

        // reload, then reset at bank 1 address 2
        pulse(1'b1, 1'b0);
        @(negedge clk);
        check("reload_wl_clear", weights_loaded, 0);
        for (int i = 0; i < 7; i++) begin
            stream.bit_data  = wexp[i].d;
            stream.bit_valid = 1'b1;
            @(posedge clk); #1;
        end
        stream.bit_valid = 1'b0;
        @(negedge clk);
        check("mid_write", {w_wq_oc, w_sel_oc, w_addr_oc, wx_write_oc},
              {1'b1, 2'd1, 20'd2, 1'b1});
        #1 rst = 1'b1;
        #1;
        check("arst_w", {w_wq_oc, w_sel_oc, w_addr_oc, wx_write_oc}, 0);
        check("arst_ctl", {busy, stream.bit_ready, weights_loaded}, 0);
        check("arst_lcc", {load_compute_ctrl, en_compute}, 2'b10);
        check("arst_result", result_out, 0);
        @(negedge clk);
        rst = 1'b0;
        pulse(1'b0, 1'b1);
        @(negedge clk);
        check("post_rst_rej", start_rejected, 1);
        check("post_rst_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
